// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared raster types: pattern mode enum, colour-bar table, default 640x480 timing
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // One bit per channel {r,g,b}, left to right: white,yellow,cyan,green,magenta,red,blue,black
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - registered video output bundle (position, enable, syncs, colour)
interface vga_pattern_gen_if #(
  parameter int CORDW = 10,
  parameter int COLW  = 8
);
  logic [CORDW-1:0] counter_x;
  logic [CORDW-1:0] counter_y;
  logic             sdl_de;
  logic             hsync_o;
  logic             vsync_o;
  logic             frame_o;
  logic [COLW-1:0]  red_o;
  logic [COLW-1:0]  green_o;
  logic [COLW-1:0]  blue_o;

  modport master (
    output counter_x, counter_y, sdl_de, hsync_o, vsync_o, frame_o, red_o, green_o, blue_o
  );
  modport slave (
    input  counter_x, counter_y, sdl_de, hsync_o, vsync_o, frame_o, red_o, green_o, blue_o
  );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - sx/sy raster counters, data enable, raw active-high syncs, frame-end strobe
module vga_timing #(
  parameter int CORDW    = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CORDW-1:0] sx_o,
  output logic [CORDW-1:0] sy_o,
  output logic             de_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             frame_end_o
);
  localparam logic [CORDW-1:0] LINE   = CORDW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CORDW-1:0] SCREEN = CORDW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CORDW-1:0] HA     = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] VA     = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end

  always_comb begin
    sx_d = sx_q + 1'b1;
    sy_d = sy_q;
    if (sx_q == LINE) begin
      sx_d = '0;
      sy_d = (sy_q == SCREEN) ? '0 : sy_q + 1'b1;
    end
  end

  assign sx_o        = sx_q;
  assign sy_o        = sy_q;
  assign de_o        = (sx_q < HA) && (sy_q < VA);
  assign hs_o        = (sx_q >= HS_BEG) && (sx_q < HS_END);
  assign vs_o        = (sy_q >= VS_BEG) && (sy_q < VS_END);
  assign frame_end_o = (sx_q == LINE) && (sy_q == SCREEN);

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - raster source: timing, frame-latched mode, pattern mux, output register stage
// VGA_BOUNCE_EN builds the bouncing-square mode; without it MODE_BOUNCE shows the fixed square.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int CORDW     = 10,
  parameter int COLW      = 8,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int SQ_SIZE   = 200,
  parameter int SQ_SPEED  = 2,
  parameter int CHK_SHIFT = 5,
  parameter int SQ_X0     = 220,
  parameter int SQ_X1     = 420,
  parameter int SQ_Y0     = 140,
  parameter int SQ_Y1     = 340
) (
  input  logic              clk,
  input  logic              sim_rst_n,
  input  logic [1:0]        mode_i,
  vga_pattern_gen_if.master vid
);
  localparam int               BAR_W = H_ACTIVE / 8;
  localparam logic [COLW-1:0]  WHITE = '1;
  localparam logic [COLW-1:0]  BG_B  = {1'b0, {(COLW-1){1'b1}}};

  logic [CORDW-1:0] sx, sy;
  logic             de, hs_raw, vs_raw, frame_end;

  vga_timing #(
    .CORDW(CORDW), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst_n(sim_rst_n), .sx_o(sx), .sy_o(sy), .de_o(de),
    .hs_o(hs_raw), .vs_o(vs_raw), .frame_end_o(frame_end)
  );

  mode_e mode_q, mode_d, mode_eff;
  logic  in_bounce;

  always_ff @(posedge clk or negedge sim_rst_n) begin
    if (!sim_rst_n) mode_q <= MODE_SQUARE;
    else            mode_q <= mode_d;
  end

  // Mode only changes between frames so a picture is never split across two patterns
  assign mode_d = frame_end ? mode_e'(mode_i) : mode_q;

`ifdef VGA_BOUNCE_EN
  localparam logic signed [CORDW:0] SPD   = (CORDW+1)'(SQ_SPEED);
  localparam logic signed [CORDW:0] X_MAX = (CORDW+1)'(H_ACTIVE - SQ_SIZE);
  localparam logic signed [CORDW:0] Y_MAX = (CORDW+1)'(V_ACTIVE - SQ_SIZE);
  localparam logic [CORDW:0]        SZ    = (CORDW+1)'(SQ_SIZE);

  logic [CORDW-1:0] sq_x_q, sq_x_d, sq_y_q, sq_y_d;
  logic             neg_x_q, neg_x_d, neg_y_q, neg_y_d;

  // Returns {moving_negative, position}; overshoot clamps to the bound and reverses
  function automatic logic [CORDW:0] bounce_step(input logic [CORDW-1:0] pos, input logic neg,
                                                 input logic signed [CORDW:0] max_pos);
    logic signed [CORDW:0] nxt;
    logic [CORDW:0]        res;
    nxt = neg ? $signed({1'b0, pos}) - SPD : $signed({1'b0, pos}) + SPD;
    res = {neg, nxt[CORDW-1:0]};
    if (nxt > max_pos)       res = {1'b1, max_pos[CORDW-1:0]};
    else if (nxt < $signed('0)) res = {1'b0, {CORDW{1'b0}}};
    return res;
  endfunction

  always_ff @(posedge clk or negedge sim_rst_n) begin
    if (!sim_rst_n) begin
      sq_x_q  <= '0;
      sq_y_q  <= '0;
      neg_x_q <= 1'b0;
      neg_y_q <= 1'b0;
    end else begin
      sq_x_q  <= sq_x_d;
      sq_y_q  <= sq_y_d;
      neg_x_q <= neg_x_d;
      neg_y_q <= neg_y_d;
    end
  end

  always_comb begin
    {neg_x_d, sq_x_d} = {neg_x_q, sq_x_q};
    {neg_y_d, sq_y_d} = {neg_y_q, sq_y_q};
    if (frame_end) begin
      {neg_x_d, sq_x_d} = bounce_step(sq_x_q, neg_x_q, X_MAX);
      {neg_y_d, sq_y_d} = bounce_step(sq_y_q, neg_y_q, Y_MAX);
    end
  end

  assign in_bounce = ({1'b0, sx} >= {1'b0, sq_x_q}) && ({1'b0, sx} < {1'b0, sq_x_q} + SZ) &&
                     ({1'b0, sy} >= {1'b0, sq_y_q}) && ({1'b0, sy} < {1'b0, sq_y_q} + SZ);
  assign mode_eff  = mode_q;
`else
  assign in_bounce = 1'b0;
  assign mode_eff  = (mode_q == MODE_BOUNCE) ? MODE_SQUARE : mode_q;
`endif

  logic [CORDW-1:0] bar_num;
  logic [2:0]       bar_idx, rgb1;
  logic             in_fixed;

  assign bar_num  = sx / CORDW'(BAR_W);
  assign bar_idx  = (bar_num > CORDW'(7)) ? 3'd7 : bar_num[2:0];
  assign rgb1     = bar_rgb(bar_idx);
  assign in_fixed = (sx > CORDW'(SQ_X0)) && (sx < CORDW'(SQ_X1)) &&
                    (sy > CORDW'(SQ_Y0)) && (sy < CORDW'(SQ_Y1));

  logic [COLW-1:0]  red_d, green_d, blue_d;
  logic [COLW-1:0]  red_q, green_q, blue_q;
  logic [CORDW-1:0] cx_q, cy_q;
  logic             de_q, hs_q, vs_q, frame_q;
  logic             hs_d, vs_d, frame_d;

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (de) begin
      case (mode_eff)
        MODE_BARS: begin
          red_d   = {COLW{rgb1[2]}};
          green_d = {COLW{rgb1[1]}};
          blue_d  = {COLW{rgb1[0]}};
        end
        MODE_CHECK: begin
          if (sx[CHK_SHIFT] ^ sy[CHK_SHIFT]) {red_d, green_d, blue_d} = {WHITE, WHITE, WHITE};
        end
        MODE_BOUNCE: begin
          if (in_bounce) {red_d, green_d, blue_d} = {WHITE, WHITE, WHITE};
          else           blue_d = BG_B;
        end
        default: begin
          if (in_fixed) {red_d, green_d, blue_d} = {WHITE, WHITE, WHITE};
          else          blue_d = BG_B;
        end
      endcase
    end
  end

  assign hs_d    = hs_raw ? H_POL : !H_POL;
  assign vs_d    = vs_raw ? V_POL : !V_POL;
  assign frame_d = (sx == '0) && (sy == '0);

  always_ff @(posedge clk or negedge sim_rst_n) begin
    if (!sim_rst_n) begin
      cx_q    <= '0;
      cy_q    <= '0;
      de_q    <= 1'b0;
      hs_q    <= !H_POL;
      vs_q    <= !V_POL;
      frame_q <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      cx_q    <= sx;
      cy_q    <= sy;
      de_q    <= de;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      frame_q <= frame_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign vid.counter_x = cx_q;
  assign vid.counter_y = cy_q;
  assign vid.sdl_de    = de_q;
  assign vid.hsync_o   = hs_q;
  assign vid.vsync_o   = vs_q;
  assign vid.frame_o   = frame_q;
  assign vid.red_o     = red_q;
  assign vid.green_o   = green_q;
  assign vid.blue_o    = blue_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - pixel-by-pixel check of vga_pattern_gen against a raster-index reference model
module tb_vga_pattern_gen;
  localparam int CORDW = 10;
  localparam int COLW  = 5;
  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 40, VFP = 2, VSY = 3, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam bit HPOL = 1'b1, VPOL = 1'b0;
  localparam int SQ = 20, SPEED = 7, CS = 3;
  localparam int FX0 = 10, FX1 = 40, FY0 = 8, FY1 = 30;
  localparam int WH = (1 << COLW) - 1;
  localparam int BGB = (1 << (COLW - 1)) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode_i = 2'd0;

  int checks = 0;
  int failures = 0;
  int n, cur_mode, next_mode, bx, by, bdx, bdy;
  int bar_tab[8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  always #5 clk = ~clk;

  vga_pattern_gen_if #(.CORDW(CORDW), .COLW(COLW)) vid ();

  vga_pattern_gen #(
    .CORDW(CORDW), .COLW(COLW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .H_POL(HPOL), .V_POL(VPOL),
    .SQ_SIZE(SQ), .SQ_SPEED(SPEED), .CHK_SHIFT(CS),
    .SQ_X0(FX0), .SQ_X1(FX1), .SQ_Y0(FY0), .SQ_Y1(FY1)
  ) dut (
    .clk(clk), .sim_rst_n(rst_n), .mode_i(mode_i), .vid(vid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s pixel=%0d got=%h expected=%h", tag, n, got, exp);
    end
  endtask

  function automatic logic [63:0] observed();
    return {25'd0, vid.counter_x, vid.counter_y, vid.sdl_de, vid.hsync_o, vid.vsync_o,
            vid.frame_o, vid.red_o, vid.green_o, vid.blue_o};
  endfunction

  task automatic bounce_axis(inout int p, inout int d, input int maxp);
    int nx;
    nx = p + d * SPEED;
    if (nx > maxp)   begin p = maxp; d = -1; end
    else if (nx < 0) begin p = 0;    d = 1;  end
    else p = nx;
  endtask

  function automatic logic [63:0] expected(input int nn);
    int x, y, r, g, b, rgb;
    logic de, hs, vs, fr;
    x  = nn % HT;
    y  = (nn / HT) % VT;
    de = (x < HA) && (y < VA);
    hs = (x >= HA + HFP && x < HA + HFP + HSY) ? HPOL : !HPOL;
    vs = (y >= VA + VFP && y < VA + VFP + VSY) ? VPOL : !VPOL;
    fr = (x == 0) && (y == 0);
    r = 0; g = 0; b = 0;
    if (de) begin
      case (cur_mode)
        1: begin
          rgb = bar_tab[(x / (HA / 8)) > 7 ? 7 : x / (HA / 8)];
          r = rgb[2] ? WH : 0; g = rgb[1] ? WH : 0; b = rgb[0] ? WH : 0;
        end
        2: if ((((x >> CS) ^ (y >> CS)) & 1) == 1) begin r = WH; g = WH; b = WH; end
`ifdef VGA_BOUNCE_EN
        3: if (x >= bx && x < bx + SQ && y >= by && y < by + SQ) begin r = WH; g = WH; b = WH; end
           else b = BGB;
`endif
        default: if (x > FX0 && x < FX1 && y > FY0 && y < FY1) begin r = WH; g = WH; b = WH; end
                 else b = BGB;
      endcase
    end
    return {25'd0, CORDW'(x), CORDW'(y), de, hs, vs, fr, COLW'(r), COLW'(g), COLW'(b)};
  endfunction

  task automatic reset_model();
    n = -1; cur_mode = 0; next_mode = 0;
    bx = 0; by = 0; bdx = 1; bdy = 1;
  endtask

  task automatic run_cycles(input int ncyc);
    for (int i = 0; i < ncyc && failures < 50; i++) begin
      @(negedge clk);
      n++;
      if (n > 0 && n % FRAME == 0) begin
        cur_mode = next_mode;
        bounce_axis(bx, bdx, HA - SQ);
        bounce_axis(by, bdy, VA - SQ);
      end
      check("pix", observed(), expected(n));
      if ($urandom_range(0, 299) == 0) mode_i = 2'($urandom_range(0, 3));
      if (n % FRAME == FRAME / 2) mode_i = 2'((n / FRAME + 1) % 4);
      // The edge that outputs the last pixel of a frame is the one that latches mode_i
      if ((n + 1) % FRAME == FRAME - 1) next_mode = int'(mode_i);
    end
  endtask

  logic [63:0] rst_exp;

  initial begin
    rst_exp = {25'd0, 20'd0, 1'b0, !HPOL, !VPOL, 1'b0, 15'd0};
    reset_model();
    repeat (3) @(negedge clk);
    check("reset_state", observed(), rst_exp);
    rst_n = 1'b1;
    run_cycles(37);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_midline", observed(), rst_exp);
    @(negedge clk);
    check("reset_held", observed(), rst_exp);
    rst_n = 1'b1;
    reset_model();
    run_cycles(12 * FRAME + 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
